mips32_rtype_fetch_queue: RTL

Upstream neighbour of the mips32 R-type datapath. Accepts raw 32-bit instruction words over a valid/ready handshake and tags each with a program counter. Checks R-type legality, drops illegal words, and buffers legal ones in a small FIFO. Presents the head instruction and its pre-split fields to the datapath, which consumes it over a second valid/ready handshake.

---
 rtl/mips32_pkg.sv | 36 +++
 rtl/mips32_rtype_legal.sv | 28 ++
 rtl/mips32_rtype_fetch_queue.sv | 108 ++++++++++
 3 files changed

// File: rtl/mips32_pkg.sv
// Shared MIPS32 R-type encoding constants and the fetch-queue entry layout.
package mips32_pkg;

  localparam logic [5:0] OPCODE_RTYPE = 6'b000000;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } rtype_entry_t;

endpackage

// File: rtl/mips32_rtype_legal.sv
// Combinational R-type legality check: opcode must be zero and funct one of
// the supported ALU/shift operations.
module mips32_rtype_legal
  import mips32_pkg::*;
(
  input  logic [31:0] instr,
  output logic        legal
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       funct_ok;

  assign opcode = instr[OPCODE_MSB:OPCODE_LSB];
  assign funct  = instr[FUNCT_MSB:FUNCT_LSB];

  always_comb begin
    funct_ok = 1'b0;
    case (funct)
      FUNCT_ADD, FUNCT_ADDU, FUNCT_SUB, FUNCT_SUBU, FUNCT_AND, FUNCT_OR,
      FUNCT_NOR, FUNCT_SLL, FUNCT_SRL, FUNCT_SLT, FUNCT_SLTU: funct_ok = 1'b1;
      default: funct_ok = 1'b0;
    endcase
  end

  assign legal = (opcode == OPCODE_RTYPE) && funct_ok;

endmodule

// File: rtl/mips32_rtype_fetch_queue.sv
// PC-tagging fetch queue for the R-type datapath: drops illegal words, buffers
// legal ones in a small FIFO and presents the head with its decoded fields.
module mips32_rtype_fetch_queue
  import mips32_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_instr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_instr,
  output logic [31:0]             out_pc,
  output logic [4:0]              out_rs,
  output logic [4:0]              out_rt,
  output logic [4:0]              out_rd,
  output logic [4:0]              out_shamt,
  output logic [5:0]              out_funct,
  output logic [$clog2(DEPTH):0]  level,
  output logic [7:0]              illegal_cnt,
  output logic                    illegal_flag
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam int               LVL_W    = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  rtype_entry_t     mem [DEPTH];
  rtype_entry_t     head;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [31:0]      pc;
  logic             word_legal;
  logic             accept;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;

  mips32_rtype_legal u_legal (
    .instr (in_instr),
    .legal (word_legal)
  );

  assign full      = (level == LVL_FULL);
  assign empty     = (level == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;

  // flush suppresses the FIFO side only; pc and illegal bookkeeping still see accept
  assign accept = in_valid && in_ready;
  assign push   = accept && word_legal && !flush;
  assign pop    = out_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc           <= PC_RESET;
      illegal_cnt  <= '0;
      illegal_flag <= 1'b0;
    end else if (accept) begin
      pc <= pc + 32'd4;
      if (!word_legal) begin
        illegal_flag <= 1'b1;
        if (illegal_cnt != 8'hFF) illegal_cnt <= illegal_cnt + 8'd1;
      end
    end
  end

  // Storage carries data only, so it needs no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{instr: in_instr, pc: pc};
  end

  assign head      = mem[rd_ptr];
  assign out_instr = out_valid ? head.instr : '0;
  assign out_pc    = out_valid ? head.pc    : '0;
  assign out_rs    = out_instr[RS_MSB:RS_LSB];
  assign out_rt    = out_instr[RT_MSB:RT_LSB];
  assign out_rd    = out_instr[RD_MSB:RD_LSB];
  assign out_shamt = out_instr[SHAMT_MSB:SHAMT_LSB];
  assign out_funct = out_instr[FUNCT_MSB:FUNCT_LSB];

endmodule
